frog_ctrl: RTL
==============

# frog_ctrl

Parametrised frog controller for the Frogger game, the next generation of the frog movement logic. It takes four debounced direction buttons and a collision flag, and moves the frog on a configurable cell grid. It also tracks level, lives and game state. Pixel coordinates are emitted for the VGA renderer and the collision checker.

## Interface
Parameters:
- H_CELLS, 20: grid columns (640 px / 32).
- V_CELLS, 15: grid rows (480 px / 32). Row 0 is the goal row.
- CELL_SHIFT, 5: log2 of the cell size in pixels.
- START_COL, 10: spawn column. Spawn row is always V_CELLS-1.
- LEVEL_W, 4: level counter width.
- LIVES, 3: lives at reset and restart (1..7).
- DEATH_CYCLES, 8: length of the dying phase in clocks (≥2).
- REPEAT_DELAY, 16: auto-repeat initial delay in clocks.
- REPEAT_PERIOD, 4: auto-repeat interval in clocks.

Ports:
- i_Clk, in, 1: system clock.
- i_Reset, in, 1: synchronous, active-high reset.
- i_Btn, in, 4: debounced buttons: [0] left, [1] down, [2] up, [3] right.
- i_Hit, in, 1: collision with a car or water, sampled every clock.
- o_Frog_X, out, 10: pixel x = col << CELL_SHIFT.
- o_Frog_Y, out, 10: pixel y = row << CELL_SHIFT.
- o_Level, out, LEVEL_W: current level, 1-based.
- o_Lives, out, 3: remaining lives.
- o_Level_Up, out, 1: one-clock pulse on reaching the goal.
- o_Dead, out, 1: high during the dying phase (renderer blinks the frog).
- o_Game_Over, out, 1: high in GAME_OVER.

## Operation
- The FSM has three states: PLAY, DYING, GAME_OVER.
- Reset values: state PLAY, col START_COL, row V_CELLS-1, level 1, lives LIVES, o_Level_Up 0, o_Dead 0, o_Game_Over 0.
- Move request: the rising edge of a button, from the registered previous i_Btn. Auto-repeat pulses also count when compiled in.
- At most one move per clock. Priority is up > down > left > right.
- Edges that lose priority in a clock are dropped, not queued.
- Moves act only in PLAY. Moves stop at the edges:
  - left is ignored at col 0;
  - right is ignored at col H_CELLS-1;
  - down is ignored at row V_CELLS-1.
- Goal: an up move from row 1 does not enter row 0. Instead:
  - o_Level_Up pulses;
  - the level increments and saturates at 2^LEVEL_W-1;
  - the frog respawns at (START_COL, V_CELLS-1).
- Hit: i_Hit in PLAY takes precedence over any move in the same clock.
  - The state goes to DYING, lives decrement, and the position holds.
  - The DYING counter loads DEATH_CYCLES-1.
- DYING: i_Hit and the buttons are ignored; o_Dead=1.
  - When the counter reaches 0 with lives>0, the frog respawns at spawn and the state goes to PLAY.
  - When the counter reaches 0 with lives==0, the state goes to GAME_OVER.
- GAME_OVER: the position is frozen; i_Hit and single buttons are ignored.
- Restart: all four i_Btn high in the same clock, in any state.
  - Restores every reset value, then enters PLAY.
  - Restart has the highest priority, above hit and moves.
  - No move is generated from the restart edges.
  - Edge detection on the following clock sees the buttons as already high.
- i_Hit is level-sensitive. A hit still asserted on the first PLAY clock after respawn kills again. The collision checker must deassert it.

## Timing
- Button edge at clock n updates col/row at clock n+1.
- o_Frog_X and o_Frog_Y are combinational shifts of the registered col/row, so they also update at clock n+1.
- o_Level_Up is high for exactly the clock in which the respawn position appears. o_Level updates in that same clock.
- Hit at clock n: o_Dead=1 and lives decremented from n+1. o_Dead stays high for DEATH_CYCLES clocks. The respawn or o_Game_Over appears at n+1+DEATH_CYCLES.
- Restart at clock n: all outputs show reset values at n+1.
- i_Reset overrides everything, including mid-DYING and mid-repeat.

## Configuration
- FROG_AUTOREPEAT_EN defined:
  - A single held button (the highest-priority held one) generates its first repeat REPEAT_DELAY clocks after its edge, then one every REPEAT_PERIOD clocks.
  - The repeat counter clears on release, on a change of held button, outside PLAY, and on reset.
- FROG_AUTOREPEAT_EN undefined: moves come only from rising edges, and the repeat counter logic is absent.

## Test plan
1. Reset, then pulse up 3 times → row 14→11, o_Frog_Y 448→352, o_Frog_X stays 320.
2. From col 0, pulse left → col stays 0. From col 19, pulse right → col stays 19. At row 14, pulse down → no change.
3. Walk the frog to row 1, then pulse up → o_Level_Up is one clock, level 1→2, and o_Frog_X/o_Frog_Y are 320/448 in the same clock. At level 15, a goal keeps level at 15.
4. i_Hit together with an up edge → no move, o_Dead=1 for 8 clocks, lives 3→2, respawn at (320,448). After three hits → o_Game_Over=1, and buttons have no effect.
5. In GAME_OVER, hold all four buttons for one clock → next clock lives=3, level=1, state PLAY, no move.
6. With FROG_AUTOREPEAT_EN, hold right for 30 clocks from col 10 → moves at edge+1, +17, +21, +25, +29, ending at col 15. Without the macro → col 11.

Source files
------------

// File: rtl/frog_ctrl_if.sv
//----------------------------------------------------------------------------
// frog_ctrl_if : button/hit inputs and position/status outputs of frog_ctrl
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface frog_ctrl_if #(
    parameter int LEVEL_W = 4
);
    logic [3:0]         i_Btn;
    logic               i_Hit;
    logic [9:0]         o_Frog_X;
    logic [9:0]         o_Frog_Y;
    logic [LEVEL_W-1:0] o_Level;
    logic [2:0]         o_Lives;
    logic               o_Level_Up;
    logic               o_Dead;
    logic               o_Game_Over;

    modport master (
        output i_Btn, i_Hit,
        input  o_Frog_X, o_Frog_Y, o_Level, o_Lives, o_Level_Up, o_Dead, o_Game_Over
    );

    modport slave (
        input  i_Btn, i_Hit,
        output o_Frog_X, o_Frog_Y, o_Level, o_Lives, o_Level_Up, o_Dead, o_Game_Over
    );
endinterface

`default_nettype wire

// File: rtl/frog_ctrl.sv
//----------------------------------------------------------------------------
// frog_ctrl : Frogger frog movement, level, lives and game-state controller.
// Optional macro FROG_AUTOREPEAT_EN adds held-button auto-repeat.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module frog_ctrl #(
    parameter int H_CELLS       = 20,
    parameter int V_CELLS       = 15,
    parameter int CELL_SHIFT    = 5,
    parameter int START_COL     = 10,
    parameter int LEVEL_W       = 4,
    parameter int LIVES         = 3,
    parameter int DEATH_CYCLES  = 8,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  wire logic  i_Clk,
    input  wire logic  i_Reset,
    frog_ctrl_if.slave bus
);
    localparam int COL_W  = (H_CELLS > 1) ? $clog2(H_CELLS) : 1;
    localparam int ROW_W  = (V_CELLS > 1) ? $clog2(V_CELLS) : 1;
    localparam int DCNT_W = $clog2(DEATH_CYCLES);

    localparam logic [COL_W-1:0]   SPAWN_COL  = COL_W'(START_COL);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(H_CELLS - 1);
    localparam logic [ROW_W-1:0]   SPAWN_ROW  = ROW_W'(V_CELLS - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = {LEVEL_W{1'b1}};
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [DCNT_W-1:0]  DCNT_LOAD  = DCNT_W'(DEATH_CYCLES - 1);

    localparam logic [1:0] S_PLAY  = 2'd0;
    localparam logic [1:0] S_DYING = 2'd1;
    localparam logic [1:0] S_OVER  = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [LEVEL_W-1:0] level;
    logic [2:0]         lives;
    logic [DCNT_W-1:0]  dcnt;
    logic               level_up;
    logic [3:0]         btn_prev;
    logic [3:0]         btn_rise;
    logic [3:0]         move_req;
    logic               restart;
    logic               mv_up, mv_down, mv_left, mv_right;

    assign restart  = &bus.i_Btn;
    assign btn_rise = bus.i_Btn & ~btn_prev;

`ifdef FROG_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [3:0]       held_sel;
    logic [3:0]       rpt_sel;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_fire;

    // Only the highest-priority held button is eligible for repeat
    always_comb begin
        held_sel = 4'b0000;
        if (bus.i_Btn[2])      held_sel = 4'b0100;
        else if (bus.i_Btn[1]) held_sel = 4'b0010;
        else if (bus.i_Btn[0]) held_sel = 4'b0001;
        else if (bus.i_Btn[3]) held_sel = 4'b1000;
    end

    // rpt_cnt counts clocks since the selected button's edge; reloading
    // after a fire makes the next fire land REPEAT_PERIOD clocks later.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || restart || state != S_PLAY || held_sel == 4'b0000) begin
            rpt_sel <= 4'b0000;
            rpt_cnt <= '0;
        end else if (held_sel != rpt_sel) begin
            rpt_sel <= held_sel;
            rpt_cnt <= RPT_W'(1);
        end else if (rpt_cnt == RPT_FIRE) begin
            rpt_cnt <= RPT_RELOAD;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end

    assign rpt_fire = (held_sel != 4'b0000) && (held_sel == rpt_sel) && (rpt_cnt == RPT_FIRE);
    assign move_req = btn_rise | (rpt_fire ? held_sel : 4'b0000);
`else
    assign move_req = btn_rise;
`endif

    // Losing requests are dropped even when the winner is blocked at an edge
    always_comb begin
        mv_up    = move_req[2];
        mv_down  = !move_req[2] && move_req[1];
        mv_left  = !move_req[2] && !move_req[1] && move_req[0];
        mv_right = !move_req[2] && !move_req[1] && !move_req[0] && move_req[3];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state    <= S_PLAY;
            btn_prev <= 4'b0000;
        end else begin
            state    <= state_nxt;
            btn_prev <= bus.i_Btn;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_PLAY:  if (bus.i_Hit) state_nxt = S_DYING;
            S_DYING: if (dcnt == '0) state_nxt = (lives == 3'd0) ? S_OVER : S_PLAY;
            S_OVER:  state_nxt = S_OVER;
            default: state_nxt = S_PLAY;
        endcase
        if (restart) state_nxt = S_PLAY;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset || restart) begin
            col      <= SPAWN_COL;
            row      <= SPAWN_ROW;
            level    <= LEVEL_W'(1);
            lives    <= LIVES_INIT;
            dcnt     <= '0;
            level_up <= 1'b0;
        end else begin
            level_up <= 1'b0;
            case (state)
                S_PLAY: begin
                    if (bus.i_Hit) begin
                        lives <= lives - 3'd1;
                        dcnt  <= DCNT_LOAD;
                    end else if (mv_up) begin
                        if (row == ROW_W'(1)) begin
                            level_up <= 1'b1;
                            if (level != LEVEL_MAX) level <= level + LEVEL_W'(1);
                            col <= SPAWN_COL;
                            row <= SPAWN_ROW;
                        end else begin
                            row <= row - ROW_W'(1);
                        end
                    end else if (mv_down) begin
                        if (row != SPAWN_ROW) row <= row + ROW_W'(1);
                    end else if (mv_left) begin
                        if (col != '0) col <= col - COL_W'(1);
                    end else if (mv_right) begin
                        if (col != LAST_COL) col <= col + COL_W'(1);
                    end
                end
                S_DYING: begin
                    if (dcnt == '0) begin
                        if (lives != 3'd0) begin
                            col <= SPAWN_COL;
                            row <= SPAWN_ROW;
                        end
                    end else begin
                        dcnt <= dcnt - DCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.o_Frog_X    = 10'(col) << CELL_SHIFT;
        bus.o_Frog_Y    = 10'(row) << CELL_SHIFT;
        bus.o_Level     = level;
        bus.o_Lives     = lives;
        bus.o_Level_Up  = level_up;
        bus.o_Dead      = (state == S_DYING);
        bus.o_Game_Over = (state == S_OVER);
    end
endmodule

`default_nettype wire
